// File: rtl/jtag_dbg_bridge_pkg.sv
// jtag_dbg_pkg: shared constants and types for the JTAG debug bridge.
//   - command opcodes (bits [31:28] of a command word)
//   - bridge FSM state encoding
//   - STATUS readback bit positions
//   - value returned for a read aborted by bus timeout
package jtag_dbg_pkg;

  localparam logic [3:0] OP_SETADDR = 4'd1;
  localparam logic [3:0] OP_READ    = 4'd2;
  localparam logic [3:0] OP_CTRL    = 4'd3;
  localparam logic [3:0] OP_STATUS  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WR,
    ST_RD
  } state_t;

  // STATUS word: {16'h0, count[7:0], 5'b0, tmo, ovf, busy}
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_OVF_BIT   = 1;
  localparam int unsigned STAT_TMO_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  localparam logic [31:0] READ_ABORT_VAL = 32'hDEADDEAD;

  // One FIFO entry: sel=0 command word, sel=1 data word.
  typedef struct packed {
    logic        sel;
    logic [31:0] word;
  } cmd_t;

endpackage

// File: rtl/jtag_dbg_bridge_if.sv
// jtag_dbg_bridge_if: SoC memory-bus master port of the debug bridge.
//   addr  : word-aligned bus address      (master -> slave)
//   wdata : write data                    (master -> slave)
//   wen   : byte write enables, all-or-none (master -> slave)
//   ren   : read request                  (master -> slave)
//   rdata : read data                     (slave -> master)
//   ready : access complete               (slave -> master)
interface jtag_dbg_bridge_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, wdata, wen, ren, input rdata, ready);
  modport slave  (input addr, wdata, wen, ren, output rdata, ready);
endinterface

// File: rtl/jtag_dbg_bridge_dbg_cmd_fifo.sv
// dbg_cmd_fifo: synchronous FIFO with first-word fall-through read port.
//   clk, rstn : clock, async active-low reset (empties the FIFO)
//   push, din : write request / data; accepted if not full, or full with pop
//   pop, dout : read request / head entry (valid while !empty)
//   full, empty, count : occupancy flags and entry count
module dbg_cmd_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/jtag_dbg_bridge.sv
// jtag_dbg_bridge: turns 32-bit JTAG debug words into SoC bus accesses.
//   clk, rstn     : clk48m, async active-low reset
//   dbgreg_in/sel/strobe : debug word, 0=command 1=data, one-cycle valid
//   dbgreg_out    : read data / status readback
//   bus (master)  : addr, wdata, wen, ren, rdata, ready
//   busy          : FIFO non-empty or access in flight
//   cpu_rst       : CPU hold-in-reset request
// Optional: define JTAG_DBG_BRIDGE_CPURST_EN to register cpu_rst from
// CTRL arg[1]; otherwise cpu_rst is tied 0.
module jtag_dbg_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BUS_TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [31:0]               dbgreg_in,
  input  logic                      dbgreg_sel,
  input  logic                      dbgreg_strobe,
  output logic [31:0]               dbgreg_out,
  jtag_dbg_bridge_if.master         bus,
  output logic                      busy,
  output logic                      cpu_rst
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(BUS_TIMEOUT + 1);

  state_t          state, state_nxt;
  cmd_t            head, cur;
  logic            full, empty, pop;
  logic [CW-1:0]   count;
  logic [31:0]     addr_reg, wdata_reg;
  logic            autoinc, ovf, tmo;
  logic [TW-1:0]   tcnt;
  logic            tmo_hit;
  logic [3:0]      op;
  logic [27:0]     arg;

  assign pop     = (state == ST_IDLE) && !empty;
  assign busy    = !empty || (state != ST_IDLE);
  assign op      = cur.word[31:28];
  assign arg     = cur.word[27:0];
  assign tmo_hit = !bus.ready && (tcnt == TW'(BUS_TIMEOUT - 1));

  dbg_cmd_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (dbgreg_strobe),
    .din   ({dbgreg_sel, dbgreg_in}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!empty) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (cur.sel)             state_nxt = ST_WR;
        else if (op == OP_READ)  state_nxt = ST_RD;
        else                     state_nxt = ST_IDLE;
      end
      ST_WR, ST_RD: if (bus.ready || tmo_hit) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Requests are decoded from the state register so reset drops them at once.
  always_comb begin
    bus.wen   = '0;
    bus.ren   = 1'b0;
    bus.addr  = addr_reg;
    bus.wdata = wdata_reg;
    if (state == ST_WR) bus.wen = '1;
    if (state == ST_RD) bus.ren = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur        <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      autoinc    <= 1'b1;
      ovf        <= 1'b0;
      tmo        <= 1'b0;
      tcnt       <= '0;
      dbgreg_out <= '0;
    end else begin
      if (pop) cur <= head;
      case (state)
        ST_DECODE: begin
          tcnt <= '0;
          if (cur.sel) begin
            wdata_reg <= cur.word;
          end else begin
            case (op)
              OP_SETADDR: addr_reg <= {2'b00, arg, 2'b00};
              OP_CTRL: begin
                autoinc <= arg[0];
                if (arg[2]) begin
                  ovf <= 1'b0;
                  tmo <= 1'b0;
                end
              end
              OP_STATUS: begin
                dbgreg_out                 <= '0;
                dbgreg_out[STAT_COUNT_LSB +: 8] <= 8'(count);
                dbgreg_out[STAT_TMO_BIT]   <= tmo;
                dbgreg_out[STAT_OVF_BIT]   <= ovf;
                dbgreg_out[STAT_BUSY_BIT]  <= busy;
              end
              default: ;
            endcase
          end
        end
        ST_WR, ST_RD: begin
          if (bus.ready) begin
            if (state == ST_RD) dbgreg_out <= bus.rdata;
            if (autoinc) addr_reg <= addr_reg + 32'd4;
          end else if (tmo_hit) begin
            tmo <= 1'b1;
            if (state == ST_RD) dbgreg_out <= READ_ABORT_VAL;
            if (autoinc) addr_reg <= addr_reg + 32'd4;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
      // A dropped word sets ovf even if a CTRL clear lands in the same cycle.
      if (dbgreg_strobe && full && !pop) ovf <= 1'b1;
    end
  end

`ifdef JTAG_DBG_BRIDGE_CPURST_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cpu_rst <= 1'b0;
    else if (state == ST_DECODE && !cur.sel && op == OP_CTRL) cpu_rst <= arg[1];
  end
`else
  assign cpu_rst = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_dbg_bridge.sv
module tb_jtag_dbg_bridge;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] dbgreg_in;
  logic        dbgreg_sel;
  logic        dbgreg_strobe;
  logic [31:0] dbgreg_out;
  logic        busy;
  logic        cpu_rst;

  jtag_dbg_bridge_if bus_if ();

  jtag_dbg_bridge #(.FIFO_DEPTH(4), .BUS_TIMEOUT(1023)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .dbgreg_in     (dbgreg_in),
    .dbgreg_sel    (dbgreg_sel),
    .dbgreg_strobe (dbgreg_strobe),
    .dbgreg_out    (dbgreg_out),
    .bus           (bus_if),
    .busy          (busy),
    .cpu_rst       (cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] m_addr;
  logic        m_auto;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic sel, input logic [31:0] w);
    dbgreg_sel    = sel;
    dbgreg_in     = w;
    dbgreg_strobe = 1'b1;
    @(negedge clk);
    dbgreg_strobe = 1'b0;
  endtask

  task automatic setaddr(input logic [27:0] a);
    send(1'b0, {4'h1, a});
    m_addr = {2'b00, a, 2'b00};
  endtask

  task automatic ctrl(input logic [27:0] a);
    send(1'b0, {4'h3, a});
    m_auto = a[0];
  endtask

  task automatic wr(input logic [31:0] w);
    send(1'b1, w);
    exp_q.push_back('{rd: 1'b0, addr: m_addr, wdata: w});
    if (m_auto) m_addr = m_addr + 32'd4;
  endtask

  task automatic rd();
    send(1'b0, {4'h2, 28'h0});
    exp_q.push_back('{rd: 1'b1, addr: m_addr, wdata: 32'h0});
    if (m_auto) m_addr = m_addr + 32'd4;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'b0, n < 2000}, 32'd1);
  endtask

  task automatic wait_req(output int ok);
    int n = 0;
    while (bus_if.wen == 4'h0 && !bus_if.ren && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50) ? 1 : 0;
    chk("req_seen", {31'b0, n < 50}, 32'd1);
  endtask

  // Answer one bus access after `delay` stall cycles, checking it against the scoreboard.
  task automatic serve(input int delay, input logic [31:0] rd_val);
    int   ok;
    txn_t t;
    wait_req(ok);
    if (ok == 0) return;
    if (exp_q.size() == 0) begin
      chk("unexpected_req", 32'd1, 32'd0);
      return;
    end
    t = exp_q.pop_front();
    chk("req_addr", bus_if.addr, t.addr);
    chk("req_kind", {27'b0, bus_if.wen, bus_if.ren}, t.rd ? 32'h01 : 32'h1E);
    if (!t.rd) chk("req_wdata", bus_if.wdata, t.wdata);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req_hold", {27'b0, bus_if.wen, bus_if.ren}, t.rd ? 32'h01 : 32'h1E);
      chk("req_addr_hold", bus_if.addr, t.addr);
    end
    bus_if.ready = 1'b1;
    bus_if.rdata = rd_val;
    @(negedge clk);
    bus_if.ready = 1'b0;
    bus_if.rdata = 32'h0;
    chk("req_drop", {27'b0, bus_if.wen, bus_if.ren}, 32'h0);
    if (t.rd) chk("rd_data", dbgreg_out, rd_val);
  endtask

  task automatic status(input logic [31:0] exp);
    send(1'b0, {4'h4, 28'h0});
    wait_idle();
    chk("status", dbgreg_out, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   ok;
    txn_t t;
    rstn          = 1'b0;
    dbgreg_in     = '0;
    dbgreg_sel    = 1'b0;
    dbgreg_strobe = 1'b0;
    bus_if.ready  = 1'b0;
    bus_if.rdata  = '0;
    m_addr        = '0;
    m_auto        = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dbgreg_out", dbgreg_out, 32'h0);
    chk("rst_addr", bus_if.addr, 32'h0);
    chk("rst_wdata", bus_if.wdata, 32'h0);
    chk("rst_req", {27'b0, bus_if.wen, bus_if.ren}, 32'h0);
    chk("rst_busy_cpurst", {30'b0, busy, cpu_rst}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // ready while idle must be ignored
    bus_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.ready = 1'b0;
    chk("idle_ready_addr", bus_if.addr, 32'h0);
    chk("idle_ready_busy", {31'b0, busy}, 32'h0);

    // SETADDR + write, with strobe-to-request latency
    setaddr(28'h0000100);
    wait_idle();
    chk("setaddr", bus_if.addr, 32'h00000400);
    wr(32'h12345678);
    chk("lat_0", {28'b0, bus_if.wen}, 32'h0);
    @(negedge clk);
    chk("lat_1", {28'b0, bus_if.wen}, 32'h0);
    @(negedge clk);
    chk("lat_2", {28'b0, bus_if.wen}, 32'hF);
    serve(0, 32'h0);
    wait_idle();
    chk("autoinc_addr", bus_if.addr, 32'h00000404);

    // SETADDR + read with 5 stall cycles
    setaddr(28'h0000100);
    rd();
    serve(5, 32'hCAFEF00D);
    wait_idle();

    // overflow: six back-to-back strobes while the bus stalls
    wr(32'hA0000000);
    wr(32'hA0000001);
    wr(32'hA0000002);
    wr(32'hA0000003);
    wr(32'hA0000004);
    send(1'b1, 32'hA0000005);
    for (int i = 0; i < 5; i++) serve(2, 32'h0);
    wait_idle();
    chk("ovf_no_extra_req", {27'b0, bus_if.wen, bus_if.ren}, 32'h0);
    status(32'h00000003);

    // read timeout
    rd();
    wait_req(ok);
    t = exp_q.pop_front();
    chk("tmo_addr", bus_if.addr, t.addr);
    n = 0;
    while (bus_if.ren && n < 1100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_len", n, 32'd1023);
    chk("tmo_val", dbgreg_out, 32'hDEADDEAD);
    wait_idle();
    chk("tmo_autoinc", bus_if.addr, m_addr);
    status(32'h00000007);
    ctrl(28'h5);
    status(32'h00000001);

    // autoinc off: both writes hit the same address
    ctrl(28'h0);
    wr(32'h11111111);
    wr(32'h22222222);
    serve(1, 32'h0);
    serve(0, 32'h0);
    wait_idle();
    ctrl(28'h1);

    // top of the settable address range carries past it
    setaddr(28'hFFFFFFF);
    wr(32'h33333333);
    wr(32'h44444444);
    serve(0, 32'h0);
    serve(0, 32'h0);
    wait_idle();
    chk("carry_addr", bus_if.addr, 32'h40000004);

    // cpu_rst control
    ctrl(28'h3);
    wait_idle();
`ifdef JTAG_DBG_BRIDGE_CPURST_EN
    chk("cpu_rst_set", {31'b0, cpu_rst}, 32'h1);
`else
    chk("cpu_rst_set", {31'b0, cpu_rst}, 32'h0);
`endif
    ctrl(28'h1);
    wait_idle();
    chk("cpu_rst_clr", {31'b0, cpu_rst}, 32'h0);

    // reset during a stalled write with words buffered
    wr(32'h55555555);
    wr(32'h66666666);
    wr(32'h77777777);
    wait_req(ok);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_req", {27'b0, bus_if.wen, bus_if.ren}, 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_addr", bus_if.addr, 32'h0);
    exp_q.delete();
    m_addr = '0;
    m_auto = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", {26'b0, bus_if.wen, bus_if.ren, busy}, 32'h0);
    wr(32'h88888888);
    serve(0, 32'h0);
    wait_idle();
    chk("post_rst_addr", bus_if.addr, 32'h4);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
